dpram_porta_arbiter: RTL

- Shares port A of the team's dual-port RAM between two requesters (R0, R1) using round-robin arbitration.
- Each grant covers one burst of len+1 beats, either all reads or all writes, at consecutive addresses.
- Drives the RAM port-A pins: active-low enable, write-enable high for write, registered read data with 1-cycle latency.
- Returns read data and beat and done strobes to the granted requester. Port B is not touched.

---
 rtl/dpram_porta_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dpram_porta_arbiter.sv
// dpram_porta_arbiter: round-robin burst arbiter sharing RAM port A between R0 and R1.
// Ports: clk_A/rst_A (async, active-high); per requester i=0,1: req_i, we_i, addr_i, len_i,
//   wdata_i in; gnt_i, wtake_i, rvalid_i, rdata_i, done_i out; registered ram_en_n, ram_wr_en,
//   ram_addr, ram_din out; ram_dout in. Define DPRAM_ARB_FIXED_PRIO_EN for fixed priority (R0 wins).
module dpram_porta_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk_A,
    input  logic                  rst_A,
    input  logic                  req_0,
    input  logic                  we_0,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    input  logic [LEN_WIDTH-1:0]  len_0,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    output logic                  gnt_0,
    output logic                  wtake_0,
    output logic                  rvalid_0,
    output logic [DATA_WIDTH-1:0] rdata_0,
    output logic                  done_0,
    input  logic                  req_1,
    input  logic                  we_1,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [LEN_WIDTH-1:0]  len_1,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    output logic                  gnt_1,
    output logic                  wtake_1,
    output logic                  rvalid_1,
    output logic [DATA_WIDTH-1:0] rdata_1,
    output logic                  done_1,
    output logic                  ram_en_n,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [LEN_WIDTH-1:0]  CNT_ONE  = 1;

    state_t                state;
    logic                  owner;
    logic                  we_r;
    logic [LEN_WIDTH-1:0]  len_r;
    logic [LEN_WIDTH-1:0]  cnt;
    logic                  any_req;
    logic                  win;
    logic                  more;
`ifndef DPRAM_ARB_FIXED_PRIO_EN
    logic                  last;
`endif

    assign any_req = req_0 | req_1;
    assign more    = (cnt < len_r);

`ifdef DPRAM_ARB_FIXED_PRIO_EN
    assign win = ~req_0;
`else
    // On a tie the requester that did not win last time goes next.
    assign win = (req_0 & req_1) ? ~last : req_1;
`endif

    // Write data is consumed at the grant edge and at every edge that issues a further beat.
    assign wtake_0 = ~rst_A &
                     (((state == IDLE) & any_req & ~win & we_0) |
                      ((state == BURST) & ~owner & we_r & more));
    assign wtake_1 = ~rst_A &
                     (((state == IDLE) & any_req & win & we_1) |
                      ((state == BURST) & owner & we_r & more));

    assign rdata_0 = rvalid_0 ? ram_dout : '0;
    assign rdata_1 = rvalid_1 ? ram_dout : '0;

    always_ff @(posedge clk_A or posedge rst_A) begin
        if (rst_A) begin
            state     <= IDLE;
            owner     <= 1'b0;
            we_r      <= 1'b0;
            len_r     <= '0;
            cnt       <= '0;
            gnt_0     <= 1'b0;
            gnt_1     <= 1'b0;
            rvalid_0  <= 1'b0;
            rvalid_1  <= 1'b0;
            done_0    <= 1'b0;
            done_1    <= 1'b0;
            ram_en_n  <= 1'b1;
            ram_wr_en <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
`ifndef DPRAM_ARB_FIXED_PRIO_EN
            last      <= 1'b1;
`endif
        end else begin
            done_0   <= 1'b0;
            done_1   <= 1'b0;
            // A read beat in flight this cycle is returned by the RAM next cycle.
            rvalid_0 <= (state == BURST) & ~we_r & ~owner;
            rvalid_1 <= (state == BURST) & ~we_r & owner;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner     <= win;
`ifndef DPRAM_ARB_FIXED_PRIO_EN
                        last      <= win;
`endif
                        we_r      <= win ? we_1 : we_0;
                        len_r     <= win ? len_1 : len_0;
                        cnt       <= '0;
                        gnt_0     <= ~win;
                        gnt_1     <= win;
                        ram_en_n  <= 1'b0;
                        ram_wr_en <= win ? we_1 : we_0;
                        ram_addr  <= win ? addr_1 : addr_0;
                        ram_din   <= win ? wdata_1 : wdata_0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (more) begin
                        cnt      <= cnt + CNT_ONE;
                        ram_addr <= ram_addr + ADDR_ONE;
                        ram_din  <= owner ? wdata_1 : wdata_0;
                    end else begin
                        ram_en_n  <= 1'b1;
                        ram_wr_en <= 1'b0;
                        gnt_0     <= 1'b0;
                        gnt_1     <= 1'b0;
                        done_0    <= ~owner;
                        done_1    <= owner;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
